id_ex_stage: RTL and testbench

ID/EX pipeline register of the five-stage MIPS core, sitting directly downstream of the sign/zero immediate extender and the register file in the decode stage. It captures the decoded instruction fields, operand data, the 32-bit extended immediate and the control bundle, and presents them to the execute stage. It also supports stall (hold), flush (bubble insertion) and load-use hazard detection, and keeps a saturating bubble counter for debug.

---
 rtl/id_ex_stage_if.sv | 45 ++++
 rtl/id_ex_stage.sv | 94 +++++++++
 tb/tb_id_ex_stage.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decode-side inputs, execute-side outputs and hazard/debug signals.
// ex_valid qualifies every ex_* field; while it is 0 the data fields are stale and ex_ctrl is all zero.
interface id_ex_stage_if #(
    parameter int CNT_W = 16
);
    logic              id_valid;
    logic [31:0]       id_pc4;
    logic [31:0]       id_rs_data;
    logic [31:0]       id_rt_data;
    logic [31:0]       id_imm_ext;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic [4:0]        id_rd;
    logic [4:0]        id_shamt;
    logic [9:0]        id_ctrl;
    logic              stall;
    logic              flush;

    logic              ex_valid;
    logic [31:0]       ex_pc4;
    logic [31:0]       ex_rs_data;
    logic [31:0]       ex_rt_data;
    logic [31:0]       ex_imm_ext;
    logic [4:0]        ex_rs;
    logic [4:0]        ex_rt;
    logic [4:0]        ex_rd;
    logic [4:0]        ex_shamt;
    logic [9:0]        ex_ctrl;
    logic              load_use_stall;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output id_valid, id_pc4, id_rs_data, id_rt_data, id_imm_ext,
               id_rs, id_rt, id_rd, id_shamt, id_ctrl, stall, flush,
        input  ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm_ext,
               ex_rs, ex_rt, ex_rd, ex_shamt, ex_ctrl, load_use_stall, bubble_cnt
    );

    modport slave (
        input  id_valid, id_pc4, id_rs_data, id_rt_data, id_imm_ext,
               id_rs, id_rt, id_rd, id_shamt, id_ctrl, stall, flush,
        output ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm_ext,
               ex_rs, ex_rt, ex_rd, ex_shamt, ex_ctrl, load_use_stall, bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hold, bubble insertion, load-use detection and a
// saturating bubble counter. Priority per edge: flush > stall > load-use bubble > load.
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
);
    // ctrl = {alu_op[3:0], alu_src, reg_dst, mem_read, mem_write, mem_to_reg, reg_write}
    localparam int MEM_READ = 3;

    logic             ex_valid;
    logic [31:0]      ex_pc4;
    logic [31:0]      ex_rs_data;
    logic [31:0]      ex_rt_data;
    logic [31:0]      ex_imm_ext;
    logic [4:0]       ex_rs;
    logic [4:0]       ex_rt;
    logic [4:0]       ex_rd;
    logic [4:0]       ex_shamt;
    logic [9:0]       ex_ctrl;
    logic [CNT_W-1:0] bubble_cnt;

    logic             load_use_stall;
    logic             bubble;
    logic             load;

    // Only register state and ID inputs feed the hazard, so stall/flush cannot form a loop.
    always_comb begin
        load_use_stall = ex_valid & ex_ctrl[MEM_READ] & bus.id_valid & (ex_rt != 5'd0) &
                         ((ex_rt == bus.id_rs) | (ex_rt == bus.id_rt));
    end

    assign bubble = bus.flush | (~bus.stall & load_use_stall);
    assign load   = ~bus.flush & ~bus.stall & ~load_use_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= 10'd0;
        end else if (bubble) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= 10'd0;
        end else if (load) begin
            ex_valid <= bus.id_valid;
            ex_ctrl  <= bus.id_valid ? bus.id_ctrl : 10'd0;
        end
    end

    // Data fields simply hold through bubbles; ex_valid=0 marks them meaningless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_pc4     <= 32'd0;
            ex_rs_data <= 32'd0;
            ex_rt_data <= 32'd0;
            ex_imm_ext <= 32'd0;
            ex_rs      <= 5'd0;
            ex_rt      <= 5'd0;
            ex_rd      <= 5'd0;
            ex_shamt   <= 5'd0;
        end else if (load) begin
            ex_pc4     <= bus.id_pc4;
            ex_rs_data <= bus.id_rs_data;
            ex_rt_data <= bus.id_rt_data;
            ex_imm_ext <= bus.id_imm_ext;
            ex_rs      <= bus.id_rs;
            ex_rt      <= bus.id_rt;
            ex_rd      <= bus.id_rd;
            ex_shamt   <= bus.id_shamt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
        end else if (bubble && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.ex_valid       = ex_valid;
    assign bus.ex_pc4         = ex_pc4;
    assign bus.ex_rs_data     = ex_rs_data;
    assign bus.ex_rt_data     = ex_rt_data;
    assign bus.ex_imm_ext     = ex_imm_ext;
    assign bus.ex_rs          = ex_rs;
    assign bus.ex_rt          = ex_rt;
    assign bus.ex_rd          = ex_rd;
    assign bus.ex_shamt       = ex_shamt;
    assign bus.ex_ctrl        = ex_ctrl;
    assign bus.load_use_stall = load_use_stall;
    assign bus.bubble_cnt     = bubble_cnt;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic against a
// transaction-level model of the ID/EX register; a second instance with CNT_W=2 covers saturation.
module tb_id_ex_stage;
    localparam int unsigned CNT_MAX = 65535;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    id_ex_stage_if #(.CNT_W(16)) bus ();
    id_ex_stage_if #(.CNT_W(2))  bus_s ();

    id_ex_stage #(.CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    id_ex_stage #(.CNT_W(2))  dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

    typedef struct {
        logic        valid;
        logic [31:0] pc4;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [9:0]  ctrl;
        int unsigned cnt;
    } ex_t;

    ex_t m;
    logic [31:0] exp_q[$];

    function automatic bit model_hazard();
        return m.valid && m.ctrl[3] && bus.id_valid && (m.rt != 5'd0) &&
               ((m.rt == bus.id_rs) || (m.rt == bus.id_rt));
    endfunction

    // Advance one clock: predict what EX should hold after the edge, then wait for it.
    task automatic clock_edge();
        ex_t nxt;
        bit  squash;
        nxt = m;
        squash = bus.flush || (!bus.stall && model_hazard());
        if (squash) begin
            nxt.valid = 1'b0;
            nxt.ctrl  = 10'd0;
            if (nxt.cnt < CNT_MAX) nxt.cnt = nxt.cnt + 1;
        end else if (!bus.stall) begin
            nxt.valid   = bus.id_valid;
            nxt.pc4     = bus.id_pc4;
            nxt.rs_data = bus.id_rs_data;
            nxt.rt_data = bus.id_rt_data;
            nxt.imm     = bus.id_imm_ext;
            nxt.rs      = bus.id_rs;
            nxt.rt      = bus.id_rt;
            nxt.rd      = bus.id_rd;
            nxt.shamt   = bus.id_shamt;
            nxt.ctrl    = bus.id_valid ? bus.id_ctrl : 10'd0;
        end
        @(posedge clk);
        #1;
        m = nxt;
    endtask

    task automatic drive_id(input logic v, input logic [31:0] pc4, input logic [4:0] rs,
                            input logic [4:0] rt, input logic [9:0] ctrl);
        bus.id_valid   = v;
        bus.id_pc4     = pc4;
        bus.id_rs_data = $urandom;
        bus.id_rt_data = $urandom;
        bus.id_imm_ext = $urandom;
        bus.id_rs      = rs;
        bus.id_rt      = rt;
        bus.id_rd      = 5'($urandom_range(0, 31));
        bus.id_shamt   = 5'($urandom_range(0, 31));
        bus.id_ctrl    = ctrl;
    endtask

    task automatic test_reset();
        logic [31:0] pc;
        pc = 32'h0040_0010;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive_id(1'b1, pc, 5'd7, 5'd7, 10'h3FF);
        clock_edge();
        bus.stall = 1'b1;
        clock_edge();
        vectors++;
        if (bus.ex_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_prehold_valid: got %b expected 1", bus.ex_valid);
        end
        #2 rst_n = 1'b0;
        m = '{default: '0};
        #1;
        vectors++;
        if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 10'd0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got valid=%b ctrl=%h expected 0/000", bus.ex_valid, bus.ex_ctrl);
        end
        vectors++;
        if ({bus.ex_pc4, bus.ex_rs_data, bus.ex_rt_data, bus.ex_imm_ext,
             bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_shamt} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got pc4=%h imm=%h rt=%0d expected all 0",
                     bus.ex_pc4, bus.ex_imm_ext, bus.ex_rt);
        end
        vectors++;
        if (bus.bubble_cnt !== 16'd0 || bus_s.bubble_cnt !== 2'd0 || bus.load_use_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_cnt: got cnt=%0d cnt_s=%0d lus=%b expected 0/0/0",
                     bus.bubble_cnt, bus_s.bubble_cnt, bus.load_use_stall);
        end
        #1 rst_n = 1'b1;
        bus.stall   = 1'b0;
        bus.id_ctrl = 10'h3C1;
        clock_edge();
        vectors++;
        if (bus.ex_valid !== 1'b1 || bus.ex_pc4 !== pc || bus.ex_ctrl !== 10'h3C1) begin
            miscompares++;
            $display("FAIL reset_first_load: got valid=%b pc4=%h ctrl=%h expected 1/%h/3c1",
                     bus.ex_valid, bus.ex_pc4, bus.ex_ctrl, pc);
        end
    endtask

    task automatic test_pass_through();
        drive_id(1'b1, 32'h0040_0100, 5'd3, 5'd4, 10'h3C1);
        bus.id_imm_ext = 32'hFFFF_8000;
        clock_edge();
        vectors++;
        if (bus.ex_imm_ext !== 32'hFFFF_8000 || bus.ex_ctrl !== 10'h3C1 || bus.ex_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL pass_through: got imm=%h ctrl=%h valid=%b expected ffff8000/3c1/1",
                     bus.ex_imm_ext, bus.ex_ctrl, bus.ex_valid);
        end
        vectors++;
        if (bus.ex_pc4 !== 32'h0040_0100 || bus.ex_rs !== 5'd3 || bus.ex_rt !== 5'd4) begin
            miscompares++;
            $display("FAIL pass_fields: got pc4=%h rs=%0d rt=%0d expected 00400100/3/4",
                     bus.ex_pc4, bus.ex_rs, bus.ex_rt);
        end
        drive_id(1'b0, 32'h0040_0104, 5'd1, 5'd2, 10'h3FF);
        clock_edge();
        vectors++;
        if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 10'd0) begin
            miscompares++;
            $display("FAIL invalid_load: got valid=%b ctrl=%h expected 0/000", bus.ex_valid, bus.ex_ctrl);
        end
    endtask

    task automatic test_stall();
        int unsigned cnt0;
        drive_id(1'b1, 32'h0000_AAA0, 5'd10, 5'd11, 10'h061);
        clock_edge();
        cnt0 = m.cnt;
        drive_id(1'b1, 32'h0000_BBB0, 5'd12, 5'd13, 10'h041);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clock_edge();
            vectors++;
            if (bus.ex_pc4 !== 32'h0000_AAA0 || bus.ex_valid !== 1'b1 || bus.bubble_cnt !== 16'(cnt0)) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got pc4=%h valid=%b cnt=%0d expected 0000aaa0/1/%0d",
                         i, bus.ex_pc4, bus.ex_valid, bus.bubble_cnt, cnt0);
            end
        end
        bus.stall = 1'b0;
        clock_edge();
        vectors++;
        if (bus.ex_pc4 !== 32'h0000_BBB0 || bus.ex_ctrl !== 10'h041) begin
            miscompares++;
            $display("FAIL stall_release: got pc4=%h ctrl=%h expected 0000bbb0/041", bus.ex_pc4, bus.ex_ctrl);
        end
    endtask

    task automatic test_load_use();
        int unsigned cnt0;
        drive_id(1'b1, 32'h0000_1000, 5'd29, 5'd8, 10'h0AB);
        clock_edge();
        drive_id(1'b1, 32'h0000_1004, 5'd8, 5'd9, 10'h011);
        #1;
        vectors++;
        if (bus.load_use_stall !== 1'b1) begin
            miscompares++;
            $display("FAIL load_use_detect: got %b expected 1", bus.load_use_stall);
        end
        cnt0 = m.cnt;
        clock_edge();
        vectors++;
        if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 10'd0 || bus.bubble_cnt !== 16'(cnt0 + 1)) begin
            miscompares++;
            $display("FAIL load_use_bubble: got valid=%b ctrl=%h cnt=%0d expected 0/000/%0d",
                     bus.ex_valid, bus.ex_ctrl, bus.bubble_cnt, cnt0 + 1);
        end
        vectors++;
        if (bus.load_use_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL load_use_drop: got %b expected 0", bus.load_use_stall);
        end
        clock_edge();
        vectors++;
        if (bus.ex_valid !== 1'b1 || bus.ex_pc4 !== 32'h0000_1004 || bus.ex_rs !== 5'd8) begin
            miscompares++;
            $display("FAIL load_use_resume: got valid=%b pc4=%h rs=%0d expected 1/00001004/8",
                     bus.ex_valid, bus.ex_pc4, bus.ex_rs);
        end
        // Load targeting $zero never creates a dependence.
        drive_id(1'b1, 32'h0000_2000, 5'd29, 5'd0, 10'h0AB);
        clock_edge();
        drive_id(1'b1, 32'h0000_2004, 5'd0, 5'd0, 10'h011);
        #1;
        vectors++;
        if (bus.load_use_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL load_use_zero: got %b expected 0", bus.load_use_stall);
        end
        cnt0 = m.cnt;
        clock_edge();
        vectors++;
        if (bus.ex_valid !== 1'b1 || bus.ex_pc4 !== 32'h0000_2004 || bus.bubble_cnt !== 16'(cnt0)) begin
            miscompares++;
            $display("FAIL load_use_zero_load: got valid=%b pc4=%h cnt=%0d expected 1/00002004/%0d",
                     bus.ex_valid, bus.ex_pc4, bus.bubble_cnt, cnt0);
        end
    endtask

    task automatic test_flush_stall();
        int unsigned cnt0;
        drive_id(1'b1, 32'h0000_3000, 5'd1, 5'd2, 10'h3C5);
        clock_edge();
        cnt0 = m.cnt;
        bus.flush = 1'b1;
        bus.stall = 1'b1;
        clock_edge();
        vectors++;
        if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 10'd0 || bus.bubble_cnt !== 16'(cnt0 + 1)) begin
            miscompares++;
            $display("FAIL flush_stall: got valid=%b ctrl=%h cnt=%0d expected 0/000/%0d",
                     bus.ex_valid, bus.ex_ctrl, bus.bubble_cnt, cnt0 + 1);
        end
        bus.flush = 1'b0;
        bus.stall = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] pc;
        logic [31:0] exp_pc;
        pc = 32'h0001_0000;
        for (int i = 0; i < 20; i++) begin
            drive_id(1'b1, pc, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                     10'($urandom_range(0, 1023)) & 10'h3F7);
            exp_q.push_back(pc);
            clock_edge();
            exp_pc = exp_q.pop_front();
            vectors++;
            if (bus.ex_valid !== 1'b1 || bus.ex_pc4 !== exp_pc) begin
                miscompares++;
                $display("FAIL back_to_back[%0d]: got valid=%b pc4=%h expected 1/%h",
                         i, bus.ex_valid, bus.ex_pc4, exp_pc);
            end
            pc = pc + 32'd4;
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt[5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        drive_id(1'b0, 32'd0, 5'd0, 5'd0, 10'd0);
        vectors++;
        if (bus_s.bubble_cnt !== 2'd0) begin
            miscompares++;
            $display("FAIL sat_start: got %0d expected 0", bus_s.bubble_cnt);
        end
        bus_s.flush = 1'b1;
        for (int i = 0; i < 5; i++) begin
            clock_edge();
            vectors++;
            if (bus_s.bubble_cnt !== exp_cnt[i] || bus_s.ex_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL saturation[%0d]: got cnt=%0d valid=%b expected %0d/0",
                         i, bus_s.bubble_cnt, bus_s.ex_valid, exp_cnt[i]);
            end
        end
        bus_s.flush = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive_id(($urandom_range(0, 3) != 0), $urandom, 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 10'($urandom_range(0, 1023)));
            bus.flush = ($urandom_range(0, 7) == 0);
            bus.stall = ($urandom_range(0, 5) == 0);
            #1;
            vectors++;
            if (bus.load_use_stall !== model_hazard()) begin
                miscompares++;
                $display("FAIL rand_hazard[%0d]: got %b expected %b", i, bus.load_use_stall, model_hazard());
            end
            clock_edge();
            vectors++;
            if (bus.ex_valid !== m.valid || bus.ex_ctrl !== m.ctrl || bus.bubble_cnt !== 16'(m.cnt)) begin
                miscompares++;
                $display("FAIL rand_ctrl[%0d]: got valid=%b ctrl=%h cnt=%0d expected %b/%h/%0d",
                         i, bus.ex_valid, bus.ex_ctrl, bus.bubble_cnt, m.valid, m.ctrl, m.cnt);
            end
            if (m.valid) begin
                vectors++;
                if ({bus.ex_pc4, bus.ex_rs_data, bus.ex_rt_data, bus.ex_imm_ext,
                     bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_shamt} !==
                    {m.pc4, m.rs_data, m.rt_data, m.imm, m.rs, m.rt, m.rd, m.shamt}) begin
                    miscompares++;
                    $display("FAIL rand_data[%0d]: got pc4=%h imm=%h rt=%0d expected %h/%h/%0d",
                             i, bus.ex_pc4, bus.ex_imm_ext, bus.ex_rt, m.pc4, m.imm, m.rt);
                end
            end
            vectors++;
            if (!bus.ex_valid && ((bus.ex_ctrl & 10'h00D) != 10'd0)) begin
                miscompares++;
                $display("FAIL rand_invariant[%0d]: got ctrl=%h with valid=0 expected side effects 0",
                         i, bus.ex_ctrl);
            end
        end
        bus.flush = 1'b0;
        bus.stall = 1'b0;
    endtask

    initial begin
        m = '{default: '0};
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive_id(1'b0, 32'd0, 5'd0, 5'd0, 10'd0);
        bus_s.id_valid   = 1'b0;
        bus_s.id_pc4     = 32'd0;
        bus_s.id_rs_data = 32'd0;
        bus_s.id_rt_data = 32'd0;
        bus_s.id_imm_ext = 32'd0;
        bus_s.id_rs      = 5'd0;
        bus_s.id_rt      = 5'd0;
        bus_s.id_rd      = 5'd0;
        bus_s.id_shamt   = 5'd0;
        bus_s.id_ctrl    = 10'd0;
        bus_s.stall      = 1'b0;
        bus_s.flush      = 1'b0;
        #12 rst_n = 1'b1;

        test_reset();
        test_pass_through();
        test_stall();
        test_load_use();
        test_flush_stall();
        test_back_to_back();
        test_saturation();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
